stream_mux_n: RTL and testbench

Parametrised N-input, WIDTH-bit multiplexer with per-channel valid/ready handshake and one registered output stage. It selects the source channel either by an external select (MODE_SEL) or by internal round-robin arbitration (MODE_RR). It replaces the fixed 8-way combinational mux in datapaths that need flow control and fair sharing.

---
 rtl/stream_mux_n_pkg.sv | 20 ++
 rtl/stream_mux_n_if.sv | 31 +++
 rtl/stream_mux_n_rr_arbiter.sv | 56 +++++
 rtl/stream_mux_n.sv | 96 +++++++++
 tb/tb_stream_mux_n.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_n_pkg.sv
// Shared types and helpers for the N-input stream multiplexer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_pkg;

    // Channel selection policy: external sel or internal round-robin.
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MAX_N = 32;

    // Index width for n channels. A 1-wide index is kept even for tiny n
    // so that no port ever collapses to zero width.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Bundle of the N upstream channels and the single downstream channel.
// Latency: none (wiring only).
// Backpressure: in_ready per channel, out_ready downstream.
// Ports: in_data/in_valid/in_ready (N channels, channel i at [i*WIDTH +: WIDTH]),
//        sel (external channel select), out_data/out_valid/out_ready/out_id.
interface stream_mux_n_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = sel_width(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_id;

    // slave: the multiplexer itself; master: whatever drives it.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_id
    );
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_id
    );
endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin pick of the first requester at or after rr_ptr, wrapping mod N.
// Latency: grant is combinational; pointer moves on the clock after advance.
// Backpressure: pointer holds whenever advance is low (no transfer / stalled).
// Ports: clk, rst_n, req[N], advance -> gnt_idx[SELW], gnt_any.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

    // rr_ptr is always < N, so one conditional subtract wraps the sum.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    // Scan offsets from far to near; the nearest requester is written last
    // and therefore wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(rr_ptr_q), k)]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(wrap_idx(int'(rr_ptr_q), k));
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-to-1 stream mux (external select or round-robin) with one output register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, combinational, 1 word/cycle.
// Ports: clk, rst_n (async active-low), bus (stream_mux_n_if.slave).
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int        WIDTH = 8,
    parameter int        N     = 8,
    parameter int        SELW  = sel_width(N),
    parameter mux_mode_e MODE  = MODE_SEL
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_mux_n_if.slave bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_id_q,    out_id_d;

    logic             can_load;
    logic             cand_ok;
    logic [SELW-1:0]  cand_idx;
    logic [WIDTH-1:0] cand_data;
    logic             xfer;

    assign can_load = !out_valid_q || bus.out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            // sel has no meaning in round-robin mode.
            logic unused_sel;
            assign unused_sel = ^bus.sel;

            rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (bus.in_valid),
                .advance (xfer),
                .gnt_idx (cand_idx),
                .gnt_any (cand_ok)
            );
        end else begin : g_sel
            // Out-of-range sel (possible when N is not a power of 2) selects nothing.
            assign cand_idx = bus.sel;
            assign cand_ok  = (int'(bus.sel) < N);
        end
    endgenerate

    // One-hot ready decode. It deliberately ignores in_valid in select mode
    // and is forced low while reset is held.
    always_comb begin
        bus.in_ready = '0;
        cand_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_idx == SELW'(i)) begin
                bus.in_ready[i] = rst_n && cand_ok && can_load;
                cand_data       = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(bus.in_ready & bus.in_valid);

    // Load wins over drain, so drain+load in one cycle keeps out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = cand_data;
            out_id_d    = cand_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: three instances (select N=8, round-robin N=4,
// select N=5) driven from one stimulus process and checked every cycle
// against a queue-free behavioural model, plus directed literal checks.
module tb_stream_mux_n;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam int ND = 3;
    int nn [ND] = '{8, 4, 5};   // channel counts; instance 1 is round-robin

    // Stimulus arrays shared by all instances (channel c at [c*8 +: 8]).
    logic [255:0] din  [ND];
    logic [31:0]  vld  [ND];
    logic [2:0]   sela [ND];
    logic         ordy [ND];

    // DUT outputs, widened for uniform comparison.
    logic [31:0] rdy_o [ND];
    logic        val_o [ND];
    logic [7:0]  dat_o [ND];
    logic [31:0] id_o  [ND];

    stream_mux_n_if #(.WIDTH(8), .N(8)) if0 ();
    stream_mux_n_if #(.WIDTH(8), .N(4)) if1 ();
    stream_mux_n_if #(.WIDTH(8), .N(5)) if2 ();

    stream_mux_n #(.WIDTH(8), .N(8), .MODE(MODE_SEL)) u_sel8 (.clk(clk), .rst_n(rst_n), .bus(if0));
    stream_mux_n #(.WIDTH(8), .N(4), .MODE(MODE_RR))  u_rr4  (.clk(clk), .rst_n(rst_n), .bus(if1));
    stream_mux_n #(.WIDTH(8), .N(5), .MODE(MODE_SEL)) u_sel5 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_data = din[0][63:0];  assign if0.in_valid = vld[0][7:0];
    assign if0.sel = sela[0];           assign if0.out_ready = ordy[0];
    assign if1.in_data = din[1][31:0];  assign if1.in_valid = vld[1][3:0];
    assign if1.sel = sela[1][1:0];      assign if1.out_ready = ordy[1];
    assign if2.in_data = din[2][39:0];  assign if2.in_valid = vld[2][4:0];
    assign if2.sel = sela[2];           assign if2.out_ready = ordy[2];

    assign rdy_o[0] = 32'(if0.in_ready); assign val_o[0] = if0.out_valid;
    assign dat_o[0] = if0.out_data;      assign id_o[0]  = 32'(if0.out_id);
    assign rdy_o[1] = 32'(if1.in_ready); assign val_o[1] = if1.out_valid;
    assign dat_o[1] = if1.out_data;      assign id_o[1]  = 32'(if1.out_id);
    assign rdy_o[2] = 32'(if2.in_ready); assign val_o[2] = if2.out_valid;
    assign dat_o[2] = if2.out_data;      assign id_o[2]  = 32'(if2.out_id);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       m_val [ND];
    logic [7:0] m_dat [ND];
    int         m_id  [ND];
    int         m_ptr [ND];

    // Channel that currently holds the grant, or -1 if none.
    function automatic int pick(input int d);
        if (d == 1) begin
            for (int k = 0; k < nn[d]; k++) begin
                int idx;
                idx = (m_ptr[d] + k) % nn[d];
                if (vld[d][idx]) return idx;
            end
            return -1;
        end
        return (int'(sela[d]) < nn[d]) ? int'(sela[d]) : -1;
    endfunction

    function automatic logic [31:0] exp_ready(input int d);
        int p;
        p = pick(d);
        if (!rst_n || p < 0 || !(!m_val[d] || ordy[d])) return 32'h0;
        return 32'h1 << p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                m_val[d] = 1'b0; m_dat[d] = 8'h0; m_id[d] = 0; m_ptr[d] = 0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                int p;
                p = pick(d);
                if (exp_ready(d) != 0 && vld[d][p]) begin
                    m_val[d] = 1'b1;
                    m_dat[d] = din[d][p*8 +: 8];
                    m_id[d]  = p;
                    if (d == 1) m_ptr[d] = (p + 1) % nn[d];
                end else if (ordy[d]) begin
                    m_val[d] = 1'b0;
                end
            end
        end
    end

    // Single compare process: 2 time units after each falling edge, i.e.
    // after the stimulus for the coming rising edge has settled.
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("u%0d.in_ready", d), rdy_o[d], exp_ready(d));
            chk($sformatf("u%0d.out_valid", d), 32'(val_o[d]), 32'(m_val[d]));
            chk($sformatf("u%0d.out_data", d), 32'(dat_o[d]), 32'(m_dat[d]));
            chk($sformatf("u%0d.out_id", d), id_o[d], 32'(m_id[d]));
        end
    end

    task automatic idle_all();
        for (int d = 0; d < ND; d++) begin
            vld[d] = '0; ordy[d] = 1'b1; sela[d] = '0;
        end
    endtask

    task automatic randomize_inputs(input int d);
        din[d]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vld[d]  = $urandom;
        sela[d] = 3'($urandom_range(0, 7));
        ordy[d] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) din[d] = '0;
        idle_all();

        // Reset with random inputs: everything must stay quiet.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) randomize_inputs(d);
            #3;
            chk("rst.rdy0", rdy_o[0], 32'h0);
            chk("rst.rdy1", rdy_o[1], 32'h0);
            chk("rst.val2", 32'(val_o[2]), 32'h0);
        end
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        // Select-mode stream: channel 5, 0xA0..0xA9 back to back.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vld[0] = 32'hFF; sela[0] = 3'd5; ordy[0] = 1'b1;
            din[0][40 +: 8] = 8'hA0 + 8'(k);
            #3;
            chk("sel.rdy", rdy_o[0], 32'h20);
            if (k > 0) chk("sel.data", 32'(dat_o[0]), 32'hA0 + 32'(k - 1));
        end
        @(negedge clk);
        vld[0] = '0;
        #3;
        chk("sel.last", 32'(dat_o[0]), 32'hA9);
        chk("sel.id", id_o[0], 32'd5);

        // Backpressure, with sel changed in the middle of the stall.
        @(negedge clk);
        vld[0] = 32'hFF; sela[0] = 3'd5; din[0][40 +: 8] = 8'h3C; ordy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ordy[0] = 1'b0; din[0][40 +: 8] = 8'h3D;
            sela[0] = 3'd2; din[0][16 +: 8] = 8'h77;
            #3;
            chk("bp.data", 32'(dat_o[0]), 32'h3C);
            chk("bp.id", id_o[0], 32'd5);
            chk("bp.rdy", rdy_o[0], 32'h0);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        #3;
        chk("bp.release_rdy", rdy_o[0], 32'h04);
        @(negedge clk);
        vld[0] = '0;
        #3;
        chk("bp.newdata", 32'(dat_o[0]), 32'h77);
        chk("bp.newid", id_o[0], 32'd2);
        @(negedge clk);
        #3;
        chk("bp.drained", 32'(val_o[0]), 32'h0);

        // Round-robin fairness: all four channels valid for 12 cycles.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vld[1] = 32'hF; ordy[1] = 1'b1; din[1] = {$urandom, $urandom, $urandom, $urandom,
                                                    $urandom, $urandom, $urandom, $urandom};
            #3;
            chk("rr.rdy", rdy_o[1], 32'h1 << (k % 4));
            if (k > 0) chk("rr.id", id_o[1], 32'((k - 1) % 4));
        end

        // Move the pointer to 1, then sparse valid 4'b1001 must go 3,0,3.
        @(negedge clk);
        vld[1] = 32'h1;
        #3;
        chk("rr.id11", id_o[1], 32'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vld[1] = 32'h9;
            #3;
            chk("rr.wrap_rdy", rdy_o[1], (k == 1) ? 32'h1 : 32'h8);
            chk("rr.wrap_id", id_o[1], (k == 0) ? 32'd0 : ((k == 1) ? 32'd3 : 32'd0));
        end
        @(negedge clk);
        vld[1] = '0;
        #3;
        chk("rr.wrap_last", id_o[1], 32'd3);

        // Non-power-of-2: sel=6 on five channels selects nothing.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vld[2] = 32'h1F; sela[2] = 3'd6; ordy[2] = 1'b1;
            #3;
            chk("n5.rdy_oob", rdy_o[2], 32'h0);
            chk("n5.val_oob", 32'(val_o[2]), 32'h0);
        end
        @(negedge clk);
        sela[2] = 3'd4; din[2][32 +: 8] = 8'h5A;
        #3;
        chk("n5.rdy4", rdy_o[2], 32'h10);
        @(negedge clk);
        vld[2] = '0;
        #3;
        chk("n5.data", 32'(dat_o[2]), 32'h5A);
        chk("n5.id", id_o[2], 32'd4);

        // Random traffic on all instances, with one reset mid-operation.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) randomize_inputs(d);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
        end

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
